perceptron_train_core: RTL and testbench

// N-input signed perceptron with sequential MAC and on-chip perceptron-rule training.

---
 rtl/perceptron_train_core.sv | 166 ++++++++++++++++
 tb/tb_perceptron_train_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_train_core.sv
// N-input signed perceptron: serial MAC inference plus perceptron-rule weight update.
// Latency from accept edge: out_valid after N_IN+2 cycles, or 2*N_IN+3 cycles with an update.
// One sample in flight; in_ready is low from accept until the result leaves OUT; result held until out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   w_load_en/w_sel/w_bit serial MSB-first load of w[0..N_IN-1] or bias (w_sel==N_IN), IDLE only
//   in_valid/in_ready     sample handshake; x_i packed inputs, train_i/label_i training request
//   out_valid/out_ready   result handshake; y_o decision, acc_o pre-activation, upd_o weights changed
module perceptron_train_core #(
  parameter  int WIDTH = 8,
  parameter  int N_IN  = 4,
  localparam int KW    = $clog2(N_IN + 1),
  localparam int ACC_W = 2 * WIDTH + $clog2(N_IN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_load_en,
  input  logic [KW-1:0]           w_sel,
  input  logic                    w_bit,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   x_i,
  input  logic                    train_i,
  input  logic                    label_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    y_o,
  output logic [ACC_W-1:0]        acc_o,
  output logic                    upd_o
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DECIDE, S_UPDATE, S_OUT} state_t;

  localparam logic [KW-1:0] K_LAST = KW'(N_IN);

  state_t state, state_nxt;

  // Index N_IN of w_q holds the bias.
  logic signed [WIDTH-1:0]   w_q [0:N_IN];
  logic signed [WIDTH-1:0]   x_q [0:N_IN-1];
  logic                      train_q;
  logic                      label_q;
  logic [KW-1:0]             k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod_q;
  logic                      prod_vld;

  logic signed [WIDTH-1:0]   op_x;
  logic signed [WIDTH-1:0]   op_w;
  logic signed [2*WIDTH-1:0] op_x_ext;
  logic signed [2*WIDTH-1:0] op_w_ext;
  logic signed [WIDTH:0]     sum_ext;
  logic signed [WIDTH-1:0]   sat_val;
  logic                      y_now;
  logic                      mis;
  logic                      enter_out;

  assign y_now     = ~acc[ACC_W-1];
  assign mis       = train_q & (y_now != label_q);
  assign enter_out = (state != S_OUT) && (state_nxt == S_OUT);

  // Operand select by k. k==N_IN selects the bias with an implicit input of 1,
  // so the update step treats the bias as just another weight.
  always_comb begin
    op_x = WIDTH'(1);
    op_w = w_q[N_IN];
    for (int i = 0; i < N_IN; i++) begin
      if (k == KW'(i)) begin
        op_x = x_q[i];
        op_w = w_q[i];
      end
    end
    op_x_ext = {{WIDTH{op_x[WIDTH-1]}}, op_x};
    op_w_ext = {{WIDTH{op_w[WIDTH-1]}}, op_w};
  end

  // One extra bit of headroom; differing top bits mean the result left the WIDTH range.
  always_comb begin
    sum_ext = label_q ? ({op_w[WIDTH-1], op_w} + {op_x[WIDTH-1], op_x})
                      : ({op_w[WIDTH-1], op_w} - {op_x[WIDTH-1], op_x});
    sat_val = sum_ext[WIDTH-1:0];
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
      sat_val = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = reset & ~w_load_en;
        if (in_valid && in_ready) state_nxt = S_MAC;
      end
      S_MAC:    if (k == K_LAST) state_nxt = S_DECIDE;
      S_DECIDE: state_nxt = mis ? S_UPDATE : S_OUT;
      S_UPDATE: if (k == K_LAST) state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= N_IN; i++) w_q[i] <= '0;
      for (int i = 0; i < N_IN; i++)  x_q[i] <= '0;
      train_q  <= 1'b0;
      label_q  <= 1'b0;
      k        <= '0;
      acc      <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      y_o      <= 1'b0;
      acc_o    <= '0;
      upd_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_load_en && (w_sel <= K_LAST)) begin
            w_q[w_sel] <= {w_q[w_sel][WIDTH-2:0], w_bit};
          end
          if (in_valid && in_ready) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= x_i[i*WIDTH +: WIDTH];
            train_q  <= train_i;
            label_q  <= label_i;
            acc      <= {{(ACC_W-WIDTH){w_q[N_IN][WIDTH-1]}}, w_q[N_IN]};
            k        <= '0;
            prod_vld <= 1'b0;
          end
        end
        // Product is registered so the multiplier and accumulator adder sit in
        // separate cycles; the last product is absorbed on the k==N_IN cycle.
        S_MAC: begin
          if (k != K_LAST) begin
            prod_q <= op_x_ext * op_w_ext;
            k      <= k + KW'(1);
          end
          prod_vld <= (k != K_LAST);
          if (prod_vld) acc <= acc + {{(ACC_W-2*WIDTH){prod_q[2*WIDTH-1]}}, prod_q};
        end
        S_DECIDE: k <= '0;
        S_UPDATE: begin
          w_q[k] <= sat_val;
          k      <= k + KW'(1);
        end
        default: ;
      endcase
      if (enter_out) begin
        y_o   <= y_now;
        acc_o <= acc;
        upd_o <= (state == S_UPDATE);
      end
    end
  end

endmodule

// File: tb/tb_perceptron_train_core.sv
// Scoreboard bench for perceptron_train_core: directed samples with hand-computed results.
// Expected entries are queued at accept; a negedge monitor checks latency and result on handshake.
// Backpressure, load/sample priority, mid-MAC reset and saturation are exercised directly.
module tb_perceptron_train_core;
  localparam int WIDTH = 8;
  localparam int N_IN  = 4;
  localparam int KW    = 3;
  localparam int ACC_W = 19;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              w_load_en = 1'b0;
  logic [KW-1:0]     w_sel = '0;
  logic              w_bit = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_IN*WIDTH-1:0] x_i = '0;
  logic              train_i = 1'b0;
  logic              label_i = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              y_o;
  logic [ACC_W-1:0]  acc_o;
  logic              upd_o;

  perceptron_train_core #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk(clk), .reset(reset), .w_load_en(w_load_en), .w_sel(w_sel), .w_bit(w_bit),
    .in_valid(in_valid), .in_ready(in_ready), .x_i(x_i), .train_i(train_i), .label_i(label_i),
    .out_valid(out_valid), .out_ready(out_ready), .y_o(y_o), .acc_o(acc_o), .upd_o(upd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string tag;
    logic  y;
    int    acc;
    logic  u;
    int    lat;
    int    t0;
  } exp_t;

  exp_t expq[$];
  bit   seen = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: latency on first sight of out_valid, result on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (expq.size() == 0) begin
        if (!seen) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_output: got out_valid=1 with no pending sample");
        end
        seen = !out_ready;
      end else begin
        e = expq[0];
        if (!seen) begin
          seen = 1'b1;
          chk({e.tag, ".latency"}, cyc - e.t0, e.lat);
        end
        if (out_ready) begin
          void'(expq.pop_front());
          seen = 1'b0;
          chk({e.tag, ".y_o"}, y_o, e.y);
          chk({e.tag, ".acc_o"}, $signed(acc_o), e.acc);
          chk({e.tag, ".upd_o"}, upd_o, e.u);
        end
      end
    end
  end

  task automatic load_reg(input int sel, input int val);
    logic [WIDTH-1:0] v;
    v = val[WIDTH-1:0];
    for (int b = WIDTH - 1; b >= 0; b--) begin
      @(posedge clk); #1;
      w_load_en = 1'b1;
      w_sel     = sel[KW-1:0];
      w_bit     = v[b];
    end
    @(posedge clk); #1;
    w_load_en = 1'b0;
  endtask

  task automatic send(input string tag, input int x0, input int x1, input int x2, input int x3,
                      input bit tr, input bit lb, input int eacc, input bit ey, input bit eu);
    exp_t e;
    bit   ok;
    @(posedge clk); #1;
    x_i      = {x3[WIDTH-1:0], x2[WIDTH-1:0], x1[WIDTH-1:0], x0[WIDTH-1:0]};
    train_i  = tr;
    label_i  = lb;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL %s.accept_timeout: got in_ready=0 for 60 cycles expected 1", tag);
    end else begin
      e.tag = tag; e.y = ey; e.acc = eacc; e.u = eu;
      e.lat = eu ? (2 * N_IN + 3) : (N_IN + 2);
      e.t0  = cyc + 1;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (expq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL %s.drain_timeout: got %0d pending expected 0", tag, expq.size());
      expq.delete();
    end
  endtask

  task automatic run(input string tag, input int x0, input int x1, input int x2, input int x3,
                     input bit tr, input bit lb, input int eacc, input bit ey, input bit eu);
    send(tag, x0, x1, x2, x3, tr, lb, eacc, ey, eu);
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any;
    bit ok;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.in_ready_low", in_ready, 0);
      chk("rst.out_valid_low", out_valid, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst.in_ready_after", in_ready, 1);
    chk("rst.y_o", y_o, 0);
    chk("rst.acc_o", $signed(acc_o), 0);
    chk("rst.upd_o", upd_o, 0);

    // w = (1,2,-1,0), b = -3
    load_reg(0, 1);
    load_reg(1, 2);
    load_reg(2, -1);
    load_reg(3, 0);
    load_reg(4, -3);

    run("infer1",  1, 1, 1, 1, 0, 0, -1, 0, 0);
    run("train1",  1, 1, 1, 1, 1, 1, -1, 0, 1);   // w -> (2,3,0,1), b -> -2
    run("verify1", 1, 1, 1, 1, 0, 0,  4, 1, 0);
    run("mixed",  -2, 3, 5,-7, 0, 0, -4, 0, 0);
    run("correct",-2, 3, 5,-7, 1, 0, -4, 0, 0);   // right guess, no update
    run("train0",  1, 1, 1, 1, 1, 0,  4, 1, 1);   // w -> (1,2,-1,0), b -> -3
    run("verify0", 1, 1, 1, 1, 0, 0, -1, 0, 0);

    // Backpressure: acc = -3 + 3 = 0 -> y = 1
    @(posedge clk); #1;
    out_ready = 1'b0;
    send("bp", 3, 0, 0, 0, 0, 0, 0, 1, 0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp.out_valid_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold_valid", out_valid, 1);
      chk("bp.hold_in_ready", in_ready, 0);
      chk("bp.hold_y", y_o, 1);
      chk("bp.hold_acc", $signed(acc_o), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp.idle_in_ready", in_ready, 1);
    chk("bp.idle_out_valid", out_valid, 0);

    // Load strobe beats a simultaneous sample; w_sel=7 addresses nothing
    @(posedge clk); #1;
    w_load_en = 1'b1;
    w_sel     = 3'd7;
    w_bit     = 1'b1;
    in_valid  = 1'b1;
    x_i       = {8'd9, 8'd9, 8'd9, 8'd9};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld.in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    w_load_en = 1'b0;
    in_valid  = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) any = 1'b1;
    end
    chk("ld.sample_not_taken", any, 0);

    // Load strobe while in MAC must be ignored: acc = -3 + (-1*4) = -7
    send("macload", 0, 0, 4, 0, 0, 0, -7, 0, 0);
    w_load_en = 1'b1;
    w_sel     = 3'd3;
    w_bit     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    w_load_en = 1'b0;
    drain("macload");
    run("macload_v", 0, 0, 0, 2, 0, 0, -3, 0, 0);

    // Reset in the middle of MAC
    send("aborted", 1, 1, 1, 1, 0, 0, -1, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.in_ready_after", in_ready, 1);
    chk("midrst.out_valid_after", out_valid, 0);
    run("cleared", 5, -3, 7, 9, 0, 0, 0, 1, 0);

    // Saturation: w0=127, w1=127, b=-128
    load_reg(0, 127);
    load_reg(1, 127);
    load_reg(4, -128);
    run("sat_up",    100, -128, 0, 0, 1, 1, -3684, 0, 1); // w0 127, w1 -1, b -127
    run("sat_up_v",    1,    0, 0, 0, 0, 0,     0, 1, 0);
    run("sat_dn1",     2,    0, 0, 0, 1, 0,   127, 1, 1); // w0 125, b -128
    run("sat_dn2",     2,    0, 0, 0, 1, 0,   122, 1, 1); // w0 123, b stays -128
    run("sat_dn_v",    0,    0, 0, 0, 0, 0,  -128, 0, 0);
    run("sat_w1_v",    0,    3, 0, 0, 0, 0,  -131, 0, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
